// File: rtl/clock_gate_pkg.sv
// Shared types and defaults for the idle-detect clock-gate controller.
// Imported by the controller and its statistics counter.
package clock_gate_pkg;

    typedef enum logic [1:0] {
        CG_ACTIVE = 2'd0,
        CG_GATED  = 2'd1,
        CG_WAKING = 2'd2
    } cg_state_e;

    localparam int unsigned DEF_IDLE_THRESH = 16;
    localparam int unsigned DEF_WAKE_CYCLES = 2;
    localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    // count up while enabled, stick at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Idle-detect controller driving the clock_gater enable.
// Gates after a run of idle cycles, wakes on request or force.
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int unsigned IDLE_THRESH = DEF_IDLE_THRESH,
    parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i__req_valid,
    output logic             o__req_ready,
    input  logic             i__busy,
    input  logic             i__force_on,
    output logic             o__enable,
    output cg_state_e        o__state,
    output logic [CNT_W-1:0] o__gated_cycles
);

    localparam int unsigned IW = $clog2(IDLE_THRESH + 1);
    localparam int unsigned WW = $clog2(WAKE_CYCLES + 1);

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_THRESH - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    cg_state_e      state_q;
    cg_state_e      state_d;
    logic [IW-1:0]  idle_q;
    logic [IW-1:0]  idle_d;
    logic [WW-1:0]  wake_q;
    logic [WW-1:0]  wake_d;
    logic           en_d;
    logic           rdy_d;
    logic           activity;
    logic           wake_req;

    assign activity = i__req_valid | i__busy | i__force_on;
    // busy is meaningless while gated: the unit is frozen
    assign wake_req = i__req_valid | i__force_on;

    // next state, counters and registered-output values
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            CG_ACTIVE: begin
                if (activity) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = CG_GATED;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            CG_GATED: begin
                if (wake_req) begin
                    state_d = CG_WAKING;
                    wake_d  = '0;
                end
            end
            CG_WAKING: begin
                if (wake_q == WAKE_LAST) begin
                    state_d = CG_ACTIVE;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: begin
                // unused encoding: fail safe with the clock running
                state_d = CG_ACTIVE;
                idle_d  = '0;
                wake_d  = '0;
            end
        endcase
        en_d  = (state_d != CG_GATED);
        rdy_d = (state_d == CG_ACTIVE);
    end

    // state, counters and outputs; reset forces the clock on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CG_ACTIVE;
            idle_q       <= '0;
            wake_q       <= '0;
            o__enable    <= 1'b1;
            o__req_ready <= 1'b1;
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            wake_q       <= wake_d;
            o__enable    <= en_d;
            o__req_ready <= rdy_d;
        end
    end

    assign o__state = state_q;

    sat_counter #(
        .W(CNT_W)
    ) u_gated_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q == CG_GATED),
        .clr  (1'b0),
        .count(o__gated_cycles)
    );

endmodule
